// File: rtl/wei_pkg.sv
// Shared widths, record payload and popcount helper for the weight dispatcher.
package wei_pkg;

    localparam int unsigned NUMPEC    = 48;
    localparam int unsigned FLG_W     = 32;
    localparam int unsigned WEI_W     = 256;
    localparam int unsigned CNT_W     = $clog2(FLG_W + 1);
    localparam int unsigned REC_DEPTH = 4;

    typedef struct packed {
        logic [FLG_W-1:0] flg;
        logic [WEI_W-1:0] wei;
        logic [CNT_W-1:0] nzcnt;
    } wei_rec_t;

    localparam int unsigned REC_W = $bits(wei_rec_t);

    function automatic logic [CNT_W-1:0] popcount(input logic [FLG_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(FLG_W); i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/wei_dispatcher_if.sv
// Weight-GBF / CTRLWEI / PEC bundle seen by the weight dispatcher.
interface wei_dispatcher_if;
    import wei_pkg::*;

    logic              CTRLWEI_PlsFetch;
    logic              CTRLACT_FnhFrm;
    logic [NUMPEC-1:0] PECCTRLWEI_GetWei;
    logic              GBFFLGWEI_Val;
    logic              GBFWEI_Val;
    logic [FLG_W-1:0]  GBFFLGWEI_Dat;
    logic [WEI_W-1:0]  GBFWEI_Dat;
    logic              DISWEI_RdFlg;
    logic              DISWEI_RdWei;
    logic              DISWEI_RdyWei;
    logic [FLG_W-1:0]  DISWEI_Flg;
    logic [WEI_W-1:0]  DISWEI_Wei;
    logic [CNT_W-1:0]  DISWEI_NzCnt;
    logic              DISWEI_Err;

    modport master (
        output CTRLWEI_PlsFetch, CTRLACT_FnhFrm, PECCTRLWEI_GetWei,
               GBFFLGWEI_Val, GBFWEI_Val, GBFFLGWEI_Dat, GBFWEI_Dat,
        input  DISWEI_RdFlg, DISWEI_RdWei, DISWEI_RdyWei, DISWEI_Flg,
               DISWEI_Wei, DISWEI_NzCnt, DISWEI_Err
    );

    modport slave (
        input  CTRLWEI_PlsFetch, CTRLACT_FnhFrm, PECCTRLWEI_GetWei,
               GBFFLGWEI_Val, GBFWEI_Val, GBFFLGWEI_Dat, GBFWEI_Dat,
        output DISWEI_RdFlg, DISWEI_RdWei, DISWEI_RdyWei, DISWEI_Flg,
               DISWEI_Wei, DISWEI_NzCnt, DISWEI_Err
    );

endinterface

// File: rtl/wei_rec_fifo.sv
// Show-ahead record FIFO with synchronous flush; head entry is visible on rdata.
module wei_rec_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 8,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointer wrap also covers non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is datapath only; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wei_dispatcher.sv
// Weight dispatcher: gates GBF reads on fetch pulses, captures returning data one
// cycle later into a show-ahead record buffer and hands the head to the PECs.
module wei_dispatcher
    import wei_pkg::*;
#(
    parameter int unsigned DEPTH = REC_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    wei_dispatcher_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic              rd_d1;
    logic              err;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic [CW:0]       occ;
    logic              room;
    logic              issue_c;
    logic              refuse_c;
    logic              get_any;
    logic              get_multi;
    logic              push;
    logic              pop;
    wei_rec_t          rec_in;
    wei_rec_t          rec_out;

    // Occupancy counts the read still in flight so a fetch can never overrun.
    assign occ      = {1'b0, count} + (CW+1)'(rd_d1);
    assign room     = (occ < (CW+1)'(DEPTH));
    assign issue_c  = rst_n & bus.CTRLWEI_PlsFetch & bus.GBFFLGWEI_Val & bus.GBFWEI_Val
                    & ~bus.CTRLACT_FnhFrm & room;
    assign refuse_c = bus.CTRLWEI_PlsFetch & ~bus.CTRLACT_FnhFrm
                    & ~(bus.GBFFLGWEI_Val & bus.GBFWEI_Val & room);

    assign get_any   = |bus.PECCTRLWEI_GetWei;
    assign get_multi = |(bus.PECCTRLWEI_GetWei & (bus.PECCTRLWEI_GetWei - NUMPEC'(1)));
    assign pop       = get_any & ~empty;
    assign push      = rd_d1 & ~bus.CTRLACT_FnhFrm;

    always_comb begin
        rec_in       = '0;
        rec_in.flg   = bus.GBFFLGWEI_Dat;
        rec_in.wei   = bus.GBFWEI_Dat;
        rec_in.nzcnt = popcount(bus.GBFFLGWEI_Dat);
    end

    // Capture stage and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_d1 <= 1'b0;
            err   <= 1'b0;
        end else begin
            rd_d1 <= issue_c;
            if (refuse_c || get_multi || (get_any && empty)) err <= 1'b1;
        end
    end

    wei_rec_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.CTRLACT_FnhFrm),
        .push  (push),
        .wdata (rec_in),
        .pop   (pop),
        .rdata (rec_out),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Head fields read as zero when no record is held.
    assign bus.DISWEI_RdFlg  = issue_c;
    assign bus.DISWEI_RdWei  = issue_c;
    assign bus.DISWEI_RdyWei = ~empty;
    assign bus.DISWEI_Flg    = empty ? '0 : rec_out.flg;
    assign bus.DISWEI_Wei    = empty ? '0 : rec_out.wei;
    assign bus.DISWEI_NzCnt  = empty ? '0 : rec_out.nzcnt;
    assign bus.DISWEI_Err    = err;

endmodule

// File: tb/tb_wei_dispatcher.sv
// Directed/randomized bench for wei_dispatcher against a queue-based reference model.
module tb_wei_dispatcher;
    import wei_pkg::*;

    localparam int MODEL_DEPTH = 4;

    typedef struct {
        logic [FLG_W-1:0] flg;
        logic [WEI_W-1:0] wei;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wei_dispatcher_if bus();

    wei_dispatcher dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rec_t q[$];
    rec_t gbf[$];
    bit   pend;
    bit   merr;
    int   checks = 0;
    int   errors = 0;

    function automatic rec_t rnd_rec();
        rec_t r;
        r.flg = $urandom;
        for (int i = 0; i < 8; i++) r.wei[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [NUMPEC-1:0] onehot();
        logic [NUMPEC-1:0] g;
        g = NUMPEC'(1);
        return g << $urandom_range(NUMPEC-1, 0);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rdflg"}, 256'(bus.DISWEI_RdFlg), 256'(0));
        chk({tag, "_rdwei"}, 256'(bus.DISWEI_RdWei), 256'(0));
        chk({tag, "_rdy"},   256'(bus.DISWEI_RdyWei), 256'(0));
        chk({tag, "_flg"},   256'(bus.DISWEI_Flg), 256'(0));
        chk({tag, "_wei"},   256'(bus.DISWEI_Wei), 256'(0));
        chk({tag, "_nz"},    256'(bus.DISWEI_NzCnt), 256'(0));
        chk({tag, "_err"},   256'(bus.DISWEI_Err), 256'(0));
    endtask

    // One clock: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic cycle(input bit pls, input bit fnh, input logic [NUMPEC-1:0] get,
                         input bit fv = 1'b1, input bit wv = 1'b1);
        rec_t pd;
        bit   iss;
        bit   refused;
        bus.CTRLWEI_PlsFetch  = pls;
        bus.CTRLACT_FnhFrm    = fnh;
        bus.PECCTRLWEI_GetWei = get;
        bus.GBFFLGWEI_Val     = fv;
        bus.GBFWEI_Val        = wv;
        if (pend && gbf.size() > 0) pd = gbf.pop_front();
        else                        pd = rnd_rec();
        bus.GBFFLGWEI_Dat = pd.flg;
        bus.GBFWEI_Dat    = pd.wei;
        iss     = pls && fv && wv && !fnh && (q.size() + int'(pend) < MODEL_DEPTH);
        refused = pls && !fnh && !iss;

        @(negedge clk);
        chk("rd_flg", 256'(bus.DISWEI_RdFlg), 256'(iss));
        chk("rd_wei", 256'(bus.DISWEI_RdWei), 256'(iss));
        chk("rdy",    256'(bus.DISWEI_RdyWei), 256'(q.size() > 0));
        if (q.size() > 0) begin
            chk("head_flg", 256'(bus.DISWEI_Flg), 256'(q[0].flg));
            chk("head_wei", 256'(bus.DISWEI_Wei), 256'(q[0].wei));
            chk("head_nz",  256'(bus.DISWEI_NzCnt), 256'($countones(q[0].flg)));
        end
        chk("err", 256'(bus.DISWEI_Err), 256'(merr));

        if (refused)                                 merr = 1'b1;
        if ($countones(get) > 1)                     merr = 1'b1;
        if ($countones(get) > 0 && q.size() == 0)    merr = 1'b1;
        if (fnh) begin
            q.delete();
            pend = 1'b0;
        end else begin
            if ($countones(get) > 0 && q.size() > 0) void'(q.pop_front());
            if (pend) q.push_back(pd);
            pend = iss;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        bus.CTRLWEI_PlsFetch  = 1'b0;
        bus.CTRLACT_FnhFrm    = 1'b0;
        bus.PECCTRLWEI_GetWei = '0;
        bus.GBFFLGWEI_Val     = 1'b0;
        bus.GBFWEI_Val        = 1'b0;
        bus.GBFFLGWEI_Dat     = '0;
        bus.GBFWEI_Dat        = '0;
        rst_n = 1'b0;
        #2;
        chk_zero_outputs("reset");
        q.delete();
        gbf.delete();
        pend = 1'b0;
        merr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rec_t r;
        rst_n = 1'b1;
        pend  = 1'b0;
        merr  = 1'b0;
        #1;
        do_reset();

        // Pre-pipe with known flag words
        for (int i = 0; i < 3; i++) begin
            r = rnd_rec();
            r.flg = FLG_W'((1 << (i + 1)) - 1);
            gbf.push_back(r);
        end
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        idle(1);
        chk("pre_nz1", 256'(bus.DISWEI_NzCnt), 256'(1));
        cycle(1'b0, 1'b0, onehot());
        chk("pre_nz2", 256'(bus.DISWEI_NzCnt), 256'(2));
        cycle(1'b0, 1'b0, onehot());
        chk("pre_nz3", 256'(bus.DISWEI_NzCnt), 256'(3));
        cycle(1'b0, 1'b0, onehot());
        idle(1);

        // Steady state: GetWei from PEC 47, fetch one cycle later
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
        idle(2);
        for (int i = 0; i < 48; i++) begin
            cycle(1'b0, 1'b0, NUMPEC'(1) << 47);
            cycle(1'b1, 1'b0, '0);
        end
        idle(1);
        chk("steady_err", 256'(bus.DISWEI_Err), 256'(0));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, onehot());
        idle(1);

        // Underflow
        cycle(1'b0, 1'b0, onehot());
        chk("underflow_err", 256'(bus.DISWEI_Err), 256'(1));
        do_reset();

        // Multi-hot GetWei pops exactly one record
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        idle(2);
        cycle(1'b0, 1'b0, NUMPEC'(3));
        chk("multihot_err", 256'(bus.DISWEI_Err), 256'(1));
        chk("multihot_rdy", 256'(bus.DISWEI_RdyWei), 256'(1));
        cycle(1'b0, 1'b0, onehot());
        chk("multihot_empty", 256'(bus.DISWEI_RdyWei), 256'(0));
        do_reset();

        // Overflow: fifth fetch refused, four records held in order
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0);
        idle(1);
        chk("ovf_err", 256'(bus.DISWEI_Err), 256'(1));
        chk("ovf_count", 256'(q.size()), 256'(4));
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, onehot());
        idle(1);

        // Fetches refused while a GBF is not valid
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // Flush while a read is returning, with a GetWei in the same cycle
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        idle(2);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, onehot());
        chk("flush_rdy", 256'(bus.DISWEI_RdyWei), 256'(0));
        idle(2);
        cycle(1'b1, 1'b0, '0);
        idle(2);
        cycle(1'b0, 1'b0, onehot());

        // Asynchronous reset with records held and a fetch pending
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
        idle(2);
        chk("prerst_rdy", 256'(bus.DISWEI_RdyWei), 256'(1));
        bus.CTRLWEI_PlsFetch = 1'b1;
        bus.GBFFLGWEI_Val    = 1'b1;
        bus.GBFWEI_Val       = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        q.delete();
        gbf.delete();
        pend = 1'b0;
        merr = 1'b0;
        @(negedge clk);
        chk("midrst_rdflg2", 256'(bus.DISWEI_RdFlg), 256'(0));
        bus.CTRLWEI_PlsFetch = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, '0);
        idle(2);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, onehot());
        idle(1);
        chk("final_err", 256'(bus.DISWEI_Err), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
